// File: rtl/net2axis_pktgen.sv
// net2axis_pktgen: AXI4-Stream packet generator for the net2axis capture sink.
//
// Sends C_NUM_PACKETS packets after START. Packet lengths and payload are
// deterministic, so a captured file can be compared against a golden file.
// Packet k is C_MIN_LEN + (k mod (C_MAX_LEN-C_MIN_LEN+1)) bytes long.
// Stream byte j of packet k is (k + j) mod 256.
// Between packets the generator leaves C_IFG idle cycles. When the last
// packet has been accepted, DONE is set and stays set until ARESET.
//
// Ports:
//   ACLK           clock, all logic on the rising edge
//   ARESET         synchronous active-high reset
//   START          level; sampled only while idle
//   M_AXIS_T*      AXI4-Stream master (TVALID/TDATA/TKEEP/TLAST out, TREADY in)
//   DONE           all packets accepted; sticky until reset
//   PKT_COUNT      number of TLAST handshakes so far
//
// Optional feature: define NET2AXIS_PKTGEN_THROTTLE_EN to insert pseudo-random
// bubbles. A 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1) gates when a new
// beat may be presented.
module net2axis_pktgen #(
  parameter int C_TDATA_WIDTH = 32,
  parameter int C_NUM_PACKETS = 4,
  parameter int C_MIN_LEN     = 1,
  parameter int C_MAX_LEN     = 64,
  parameter int C_IFG         = 2
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       START,
  output logic                       M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                       M_AXIS_TLAST,
  input  logic                       M_AXIS_TREADY,
  output logic                       DONE,
  output logic [15:0]                PKT_COUNT
);

  localparam int          BYTES      = C_TDATA_WIDTH / 8;
  localparam int          RANGE      = C_MAX_LEN - C_MIN_LEN + 1;
  localparam logic [15:0] MIN_LEN_W  = 16'(C_MIN_LEN);
  localparam logic [15:0] LAST_IDX_W = 16'(RANGE - 1);
  localparam logic [16:0] NUM_PKT_W  = 17'(C_NUM_PACKETS);
  localparam logic [16:0] BYTES_W    = 17'(BYTES);
  localparam logic [15:0] STEP_W     = 16'(BYTES);
  localparam logic [7:0]  IFG_W      = 8'(C_IFG);

  // Illegal parameter sets stop elaboration.
  if (C_MIN_LEN < 1 || C_MAX_LEN < C_MIN_LEN || C_MAX_LEN > 65535 ||
      C_TDATA_WIDTH < 8 || (C_TDATA_WIDTH % 8) != 0) begin : g_bad_param
    $fatal(1, "net2axis_pktgen: illegal parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 tvalid_q, tvalid_d;
  logic [C_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [BYTES-1:0]     tkeep_q, tkeep_d;
  logic                 tlast_q, tlast_d;
  logic                 done_q, done_d;
  logic [15:0]          pkt_count_q, pkt_count_d;
  logic [15:0]          pkt_idx_q, pkt_idx_d;   // k mod RANGE, selects length
  logic [7:0]           pkt_k8_q, pkt_k8_d;     // k mod 256, payload base
  logic [15:0]          off_q, off_d;           // byte offset of next beat to load
  logic [7:0]           gap_q, gap_d;

  logic                 can_load_s;
  logic                 hs_s;
  logic                 pkt_adv_s;
  logic                 load_s;
  logic [15:0]          sel_idx_s, sel_off_s;
  logic [7:0]           sel_k8_s;
  logic [16:0]          len_s;
  logic [C_TDATA_WIDTH-1:0] beat_data_s;
  logic [BYTES-1:0]     beat_keep_s;
  logic                 beat_last_s;

`ifdef NET2AXIS_PKTGEN_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR; bit 0 grants permission to present a new beat.
  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    can_load_s = lfsr_q[0];
  end

  // LFSR register, advances every cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign can_load_s = 1'b1;
`endif

  assign hs_s = tvalid_q & M_AXIS_TREADY;

  // Selects which packet/offset the next loaded beat comes from. At a TLAST
  // handshake the next packet is used immediately, so IFG=0 needs no extra cycle.
  always_comb begin
    pkt_adv_s = (state_q == S_SEND) && hs_s && tlast_q;
    if (pkt_adv_s) begin
      sel_k8_s  = pkt_k8_q + 8'd1;
      sel_idx_s = (pkt_idx_q == LAST_IDX_W) ? 16'd0 : pkt_idx_q + 16'd1;
      sel_off_s = 16'd0;
    end else begin
      sel_k8_s  = pkt_k8_q;
      sel_idx_s = pkt_idx_q;
      sel_off_s = off_q;
    end
  end

  // Builds the beat at the selected offset. Lanes past the end of the packet
  // are zeroed and their keep bits cleared.
  always_comb begin
    len_s       = {1'b0, MIN_LEN_W + sel_idx_s};
    beat_data_s = {C_TDATA_WIDTH{1'b0}};
    beat_keep_s = {BYTES{1'b0}};
    for (int i = 0; i < BYTES; i++) begin
      if (({1'b0, sel_off_s} + 17'(i)) < len_s) begin
        beat_keep_s[i]         = 1'b1;
        beat_data_s[8*i +: 8]  = sel_k8_s + sel_off_s[7:0] + 8'(i);
      end else begin
        beat_keep_s[i]         = 1'b0;
        beat_data_s[8*i +: 8]  = 8'h00;
      end
    end
    beat_last_s = ({1'b0, sel_off_s} + BYTES_W) >= len_s;
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    done_d      = done_q;
    pkt_count_d = pkt_count_q;
    pkt_idx_d   = pkt_idx_q;
    pkt_k8_d    = pkt_k8_q;
    off_d       = off_q;
    gap_d       = gap_q;
    load_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (NUM_PKT_W == 17'd0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = S_SEND;
            load_s  = can_load_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (hs_s && tlast_q) begin
          pkt_count_d = pkt_count_q + 16'd1;
          pkt_k8_d    = sel_k8_s;
          pkt_idx_d   = sel_idx_s;
          off_d       = 16'd0;
          if (({1'b0, pkt_count_q} + 17'd1) == NUM_PKT_W) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else if (IFG_W != 8'd0) begin
            state_d = S_GAP;
            gap_d   = IFG_W;
          end else begin
            load_s  = can_load_s;
          end
        end else if (hs_s || !tvalid_q) begin
          load_s = can_load_s;
        end else begin
          load_s = 1'b0;  // stalled beat is held
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) begin
          state_d = S_SEND;
          load_s  = can_load_s;
        end else begin
          gap_d   = gap_q - 8'd1;
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A presented beat only changes at a handshake; otherwise the bus idles at zero.
    if (load_s) begin
      tvalid_d  = 1'b1;
      tdata_d   = beat_data_s;
      tkeep_d   = beat_keep_s;
      tlast_d   = beat_last_s;
      off_d     = sel_off_s + STEP_W;
    end else if (hs_s || state_d != S_SEND) begin
      tvalid_d  = 1'b0;
      tdata_d   = {C_TDATA_WIDTH{1'b0}};
      tkeep_d   = {BYTES{1'b0}};
      tlast_d   = 1'b0;
    end else begin
      tvalid_d  = tvalid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      tvalid_q    <= 1'b0;
      tdata_q     <= {C_TDATA_WIDTH{1'b0}};
      tkeep_q     <= {BYTES{1'b0}};
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
      pkt_count_q <= 16'd0;
      pkt_idx_q   <= 16'd0;
      pkt_k8_q    <= 8'd0;
      off_q       <= 16'd0;
      gap_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      done_q      <= done_d;
      pkt_count_q <= pkt_count_d;
      pkt_idx_q   <= pkt_idx_d;
      pkt_k8_q    <= pkt_k8_d;
      off_q       <= off_d;
      gap_q       <= gap_d;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TKEEP  = tkeep_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign DONE          = done_q;
  assign PKT_COUNT     = pkt_count_q;

endmodule
